// File: rtl/jtag_tap_param_if.sv
// JTAG pin and USER parallel-port bundle between a TAP driver and the TAP controller.
// Pure wiring; no latency and no backpressure (TCK-paced).
interface jtag_tap_param_if #(
  parameter int IR_WIDTH   = 4,
  parameter int USER_WIDTH = 16
);
  logic                  TMS;
  logic                  TDI;
  logic                  TDO;
  logic                  TDO_EN;
  logic [USER_WIDTH-1:0] USER_CAPTURE_DATA;
  logic [USER_WIDTH-1:0] USER_UPDATE_DATA;
  logic                  USER_UPDATE_STB;
  logic [3:0]            STATE;
  logic [IR_WIDTH-1:0]   IR_OUT;

  modport master (
    output TMS, TDI, USER_CAPTURE_DATA,
    input  TDO, TDO_EN, USER_UPDATE_DATA, USER_UPDATE_STB, STATE, IR_OUT
  );

  modport slave (
    input  TMS, TDI, USER_CAPTURE_DATA,
    output TDO, TDO_EN, USER_UPDATE_DATA, USER_UPDATE_STB, STATE, IR_OUT
  );
endinterface

// File: rtl/jtag_tap_param.sv
// Parametrised 1149.1 TAP with IR, BYPASS, IDCODE and a USER register with parallel capture/update.
// State/shift regs move on posedge TCK, TDO and update outputs on negedge; no backpressure (TCK-paced).
module jtag_tap_param #(
  parameter int                  IR_WIDTH     = 4,
  parameter logic [31:0]         IDCODE_VALUE = 32'hF0F0_F0F1,
  parameter int                  USER_WIDTH   = 16,
  parameter logic [IR_WIDTH-1:0] IDCODE_OPC   = IR_WIDTH'(1),
  parameter logic [IR_WIDTH-1:0] USER_OPC     = IR_WIDTH'(2)
) (
  input logic             TCK,
  input logic             TRST_N,
  jtag_tap_param_if.slave tap
);

  localparam logic [3:0] S_TLR    = 4'h0;
  localparam logic [3:0] S_UPD_IR = 4'h1;
  localparam logic [3:0] S_EX2_IR = 4'h2;
  localparam logic [3:0] S_PAU_IR = 4'h3;
  localparam logic [3:0] S_EX1_IR = 4'h4;
  localparam logic [3:0] S_SH_IR  = 4'h5;
  localparam logic [3:0] S_CAP_IR = 4'h6;
  localparam logic [3:0] S_SEL_IR = 4'h7;
  localparam logic [3:0] S_UPD_DR = 4'h8;
  localparam logic [3:0] S_EX2_DR = 4'h9;
  localparam logic [3:0] S_PAU_DR = 4'hA;
  localparam logic [3:0] S_EX1_DR = 4'hB;
  localparam logic [3:0] S_SH_DR  = 4'hC;
  localparam logic [3:0] S_CAP_DR = 4'hD;
  localparam logic [3:0] S_SEL_DR = 4'hE;
  localparam logic [3:0] S_RTI    = 4'hF;

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

  logic [3:0]            state, state_nxt;
  logic [IR_WIDTH-1:0]   ir_sr, ir_shifted, ir_out;
  logic                  bypass_sr;
  logic [31:0]           idcode_sr;
  logic [USER_WIDTH-1:0] user_sr, user_shifted, user_upd_dat;
  logic                  user_upd_stb;
  logic                  tdo, tdo_en;
  logic                  sel_idcode, sel_user, dr_tdo;

  always_comb begin
    state_nxt = state;
    case (state)
      S_TLR:    state_nxt = tap.TMS ? S_TLR    : S_RTI;
      S_RTI:    state_nxt = tap.TMS ? S_SEL_DR : S_RTI;
      S_SEL_DR: state_nxt = tap.TMS ? S_SEL_IR : S_CAP_DR;
      S_CAP_DR: state_nxt = tap.TMS ? S_EX1_DR : S_SH_DR;
      S_SH_DR:  state_nxt = tap.TMS ? S_EX1_DR : S_SH_DR;
      S_EX1_DR: state_nxt = tap.TMS ? S_UPD_DR : S_PAU_DR;
      S_PAU_DR: state_nxt = tap.TMS ? S_EX2_DR : S_PAU_DR;
      S_EX2_DR: state_nxt = tap.TMS ? S_UPD_DR : S_SH_DR;
      S_UPD_DR: state_nxt = tap.TMS ? S_SEL_DR : S_RTI;
      S_SEL_IR: state_nxt = tap.TMS ? S_TLR    : S_CAP_IR;
      S_CAP_IR: state_nxt = tap.TMS ? S_EX1_IR : S_SH_IR;
      S_SH_IR:  state_nxt = tap.TMS ? S_EX1_IR : S_SH_IR;
      S_EX1_IR: state_nxt = tap.TMS ? S_UPD_IR : S_PAU_IR;
      S_PAU_IR: state_nxt = tap.TMS ? S_EX2_IR : S_PAU_IR;
      S_EX2_IR: state_nxt = tap.TMS ? S_UPD_IR : S_SH_IR;
      S_UPD_IR: state_nxt = tap.TMS ? S_SEL_DR : S_RTI;
      default:  state_nxt = S_TLR;
    endcase
  end

  // Anything that is neither IDCODE nor USER falls back to BYPASS.
  assign sel_idcode = (ir_out == IDCODE_OPC);
  assign sel_user   = (ir_out == USER_OPC) && !sel_idcode;
  assign dr_tdo     = sel_idcode ? idcode_sr[0] : (sel_user ? user_sr[0] : bypass_sr);

  // Shift-right with TDI into the MSB; written this way so width 1 works too.
  always_comb begin
    ir_shifted                 = ir_sr >> 1;
    ir_shifted[IR_WIDTH-1]     = tap.TDI;
    user_shifted               = user_sr >> 1;
    user_shifted[USER_WIDTH-1] = tap.TDI;
  end

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      state     <= S_TLR;
      ir_sr     <= '0;
      bypass_sr <= 1'b0;
      idcode_sr <= '0;
      user_sr   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_TLR: begin
          ir_sr     <= '0;
          bypass_sr <= 1'b0;
          idcode_sr <= '0;
          user_sr   <= '0;
        end
        S_CAP_IR: ir_sr <= IR_CAPTURE;
        S_SH_IR:  ir_sr <= ir_shifted;
        S_CAP_DR: begin
          if (sel_idcode)    idcode_sr <= IDCODE_VALUE;
          else if (sel_user) user_sr   <= tap.USER_CAPTURE_DATA;
          else               bypass_sr <= 1'b0;
        end
        S_SH_DR: begin
          if (sel_idcode)    idcode_sr <= {tap.TDI, idcode_sr[31:1]};
          else if (sel_user) user_sr   <= user_shifted;
          else               bypass_sr <= tap.TDI;
        end
        default: ;
      endcase
    end
  end

  // Negedge side: TDO launch, instruction latch and USER update strobe.
  always_ff @(negedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      ir_out       <= IDCODE_OPC;
      tdo          <= 1'b0;
      tdo_en       <= 1'b0;
      user_upd_dat <= '0;
      user_upd_stb <= 1'b0;
    end else begin
      tdo_en       <= 1'b0;
      user_upd_stb <= 1'b0;
      case (state)
        S_TLR: begin
          ir_out <= IDCODE_OPC;
          tdo    <= 1'b0;
        end
        S_SH_IR: begin
          tdo    <= ir_sr[0];
          tdo_en <= 1'b1;
        end
        S_SH_DR: begin
          tdo    <= dr_tdo;
          tdo_en <= 1'b1;
        end
        S_UPD_IR: ir_out <= ir_sr;
        S_UPD_DR: begin
          if (sel_user) begin
            user_upd_dat <= user_sr;
            user_upd_stb <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign tap.STATE            = state;
  assign tap.IR_OUT           = ir_out;
  assign tap.TDO              = tdo;
  assign tap.TDO_EN           = tdo_en;
  assign tap.USER_UPDATE_DATA = user_upd_dat;
  assign tap.USER_UPDATE_STB  = user_upd_stb;

endmodule
